// File: rtl/mult_div_unit_pkg.sv
// Shared control-select encodings and result types for the multiply/divide unit.
// md_compute is pure combinational: the unit latches its result on acceptance.
package mult_div_unit_pkg;

  localparam int WIDTH_MDSEL = 3;

  typedef enum logic [WIDTH_MDSEL-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic md_result_t md_compute(md_sel_e sel, logic [31:0] a, logic [31:0] b);
    md_result_t  res;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    res   = '0;
    prod  = '0;
    mag_a = '0;
    mag_b = '0;
    uq    = '0;
    ur    = '0;
    case (sel)
      // Low 64 bits of the product of sign-extended operands equal the signed product.
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res  = prod;
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        res  = prod;
      end
      // Magnitude division keeps 0x80000000 / -1 well defined: quotient wraps to 0x80000000.
      MD_DIV: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          mag_a  = a[31] ? (~a + 32'd1) : a;
          mag_b  = b[31] ? (~b + 32'd1) : b;
          uq     = mag_a / mag_b;
          ur     = mag_a % mag_b;
          res.lo = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
          res.hi = a[31] ? (~ur + 32'd1) : ur;
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          res.hi = a;
          res.lo = 32'hFFFF_FFFF;
        end else begin
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic        MDStart;
  md_sel_e     MDSel;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MDStart, MDSel, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  MDStart, MDSel, A, B,
    output Busy, HI, LO
  );

endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit with HI/LO: result lands MULT_CYCLES/DIV_CYCLES after acceptance.
// No backpressure handshake: Busy tells the requester to stall; starts while busy are dropped.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  mult_div_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q;
  md_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  md_result_t       pend_q;
  md_result_t       hilo_q;
  md_result_t       op_result;
  logic             is_mul;
  logic             is_div;
  logic             start_long;
  logic             finish;
  logic             wr_hi;
  logic             wr_lo;
  logic             busy;

  assign op_result = md_compute(md.MDSel, md.A, md.B);
  assign is_mul    = (md.MDSel == MD_MULT) || (md.MDSel == MD_MULTU);
  assign is_div    = (md.MDSel == MD_DIV)  || (md.MDSel == MD_DIVU);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md.MDStart && (is_mul || is_div)) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Requests are only decoded in IDLE, so anything arriving during RUN (including its last cycle) is dropped.
  always_comb begin
    start_long = 1'b0;
    finish     = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_long = md.MDStart && (is_mul || is_div);
        wr_hi      = md.MDStart && (md.MDSel == MD_MTHI);
        wr_lo      = md.MDStart && (md.MDSel == MD_MTLO);
      end
      ST_RUN: begin
        busy   = 1'b1;
        finish = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      hilo_q <= '0;
    end else begin
      if (start_long) begin
        pend_q <= op_result;
        cnt_q  <= is_mul ? MULT_LOAD : DIV_LOAD;
      end else if ((state_q == ST_RUN) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (finish) begin
        hilo_q <= pend_q;
      end else begin
        if (wr_hi) hilo_q.hi <= md.A;
        if (wr_lo) hilo_q.lo <= md.A;
      end
    end
  end

  assign md.Busy = busy;
  assign md.HI   = hilo_q.hi;
  assign md.LO   = hilo_q.lo;

endmodule
